// File: rtl/ln_fp32_iter.sv
// Iterative fp32 natural logarithm: ln(m) by shift-add multiplicative
// normalisation, then E*ln2 added and the fixed-point sum renormalised.
module ln_fp32_iter #(
    parameter int MAX_ITER = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [4:0]  number_iter,
    output logic        ready,
    output logic        done,
    output logic [31:0] S
);

    typedef enum logic [2:0] {IDLE, UNPACK, ITER, COMBINE, NORM} state_t;

    localparam logic signed [39:0] LN2_Q30 = 40'sd744261118;
    localparam logic [4:0]         MAX_K   = 5'(MAX_ITER);

    state_t state, state_nx;

    logic [31:0]        a_r, x_r, spec_s_r;
    logic [4:0]         n_r, k_r, n_clamp;
    logic signed [39:0] y_r, e_ext, e_ln2;
    logic signed [8:0]  e_r;
    logic               spec_r, one_r;

    logic               a_nan, a_neg, a_pinf, a_zero, is_spec;
    logic [31:0]        spec_val;
    logic [32:0]        t;
    logic               accept;
    logic [39:0]        mag, sh;
    logic [5:0]         pos;
    logic [31:0]        norm_s;

    function automatic logic [29:0] ln_rom(input logic [4:0] k);
        unique case (k)
            5'd1:  ln_rom = 30'd435364845;
            5'd2:  ln_rom = 30'd239598564;
            5'd3:  ln_rom = 30'd126468572;
            5'd4:  ln_rom = 30'd65095192;
            5'd5:  ln_rom = 30'd33040817;
            5'd6:  ln_rom = 30'd16647494;
            5'd7:  ln_rom = 30'd8356010;
            5'd8:  ln_rom = 30'd4186133;
            5'd9:  ln_rom = 30'd2095107;
            5'd10: ln_rom = 30'd1048064;
            5'd11: ln_rom = 30'd524160;
            5'd12: ln_rom = 30'd262112;
            5'd13: ln_rom = 30'd131064;
            5'd14: ln_rom = 30'd65534;
            5'd15: ln_rom = 30'd32768;
            5'd16: ln_rom = 30'd16384;
            5'd17: ln_rom = 30'd8192;
            5'd18: ln_rom = 30'd4096;
            5'd19: ln_rom = 30'd2048;
            5'd20: ln_rom = 30'd1024;
            5'd21: ln_rom = 30'd512;
            5'd22: ln_rom = 30'd256;
            5'd23: ln_rom = 30'd128;
            5'd24: ln_rom = 30'd64;
            5'd25: ln_rom = 30'd32;
            5'd26: ln_rom = 30'd16;
            5'd27: ln_rom = 30'd8;
            5'd28: ln_rom = 30'd4;
            5'd29: ln_rom = 30'd2;
            5'd30: ln_rom = 30'd1;
            default: ln_rom = 30'd0;
        endcase
    endfunction

    always_comb begin
        n_clamp = number_iter;
        if (number_iter == 5'd0)
            n_clamp = 5'd1;
        else if (number_iter > MAX_K)
            n_clamp = MAX_K;
    end

    // negative NaN must still map to the NaN result, so order matters
    always_comb begin
        a_nan    = (&a_r[30:23]) && (|a_r[22:0]);
        a_neg    = a_r[31] && (|a_r[30:0]);
        a_pinf   = (a_r == 32'h7F80_0000);
        a_zero   = (a_r[30:23] == 8'd0);
        is_spec  = 1'b1;
        spec_val = 32'h0;
        priority case (1'b1)
            a_nan:   spec_val = 32'h7FC0_0000;
            a_neg:   spec_val = 32'h7FC0_0000;
            a_pinf:  spec_val = 32'h7F80_0000;
            a_zero:  spec_val = 32'hFF80_0000;
            default: is_spec  = 1'b0;
        endcase
    end

    always_comb begin
        t      = {1'b0, x_r} + ({1'b0, x_r} >> k_r);
        accept = (t <= 33'h0_8000_0000);
        e_ext  = {{31{e_r[8]}}, e_r};
        e_ln2  = e_ext * LN2_Q30;
    end

    always_comb begin
        mag = y_r[39] ? 40'(-y_r) : 40'(y_r);
        pos = 6'd0;
        for (int i = 0; i < 40; i++)
            if (mag[i]) pos = 6'(i);
        sh     = mag << (6'd39 - pos);
        norm_s = {y_r[39], 8'd97 + {2'b00, pos}, 23'(sh >> 16)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = UNPACK;
            UNPACK:  state_nx = is_spec ? NORM : ITER;
            ITER:    if (k_r == n_r) state_nx = COMBINE;
            COMBINE: state_nx = NORM;
            NORM:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            n_r      <= '0;
            k_r      <= '0;
            x_r      <= '0;
            y_r      <= '0;
            e_r      <= '0;
            spec_r   <= 1'b0;
            spec_s_r <= '0;
            one_r    <= 1'b0;
            done     <= 1'b0;
            S        <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= A;
                        n_r <= n_clamp;
                    end
                end
                UNPACK: begin
                    e_r      <= 9'({1'b0, a_r[30:23]}) - 9'd127;
                    x_r      <= {2'b01, a_r[22:0], 7'b0};
                    y_r      <= LN2_Q30;
                    k_r      <= 5'd1;
                    spec_r   <= is_spec;
                    spec_s_r <= spec_val;
                    one_r    <= (a_r == 32'h3F80_0000);
                end
                ITER: begin
                    if (accept) begin
                        x_r <= t[31:0];
                        y_r <= y_r - $signed({10'b0, ln_rom(k_r)});
                    end
                    k_r <= k_r + 5'd1;
                end
                COMBINE: y_r <= y_r + e_ln2;
                NORM: begin
                    done <= 1'b1;
                    if (spec_r)
                        S <= spec_s_r;
                    else if (one_r || y_r == 40'sd0)
                        S <= 32'h0;
                    else
                        S <= norm_s;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ln_fp32_iter.sv
// Directed-vector bench for ln_fp32_iter: values, latencies,
// specials, handshake and asynchronous reset.
module tb_ln_fp32_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [4:0]  number_iter;
    logic        ready;
    logic        done;
    logic [31:0] S;

    int n_cmp;
    int n_bad;

    ln_fp32_iter #(.MAX_ITER(24)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .number_iter (number_iter),
        .ready       (ready),
        .done        (done),
        .S           (S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp, input int tol = 0);
        longint d;
        n_cmp++;
        d = longint'(got) - longint'(exp);
        if (d < 0) d = -d;
        if (d > longint'(tol)) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h tol=%0d", tag, got, exp, tol);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [4:0] n,
                          output logic [31:0] s, output int lat);
        @(negedge clk);
        A           = a;
        number_iter = n;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (done) break;
        end
        s = S;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] s;
    } spec_vec_t;

    spec_vec_t specs [5];

    logic [31:0] s;
    int          lat;
    int          cyc;
    int          ndone;

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        A           = '0;
        number_iter = 5'd24;
        specs[0] = '{32'h0000_0000, 32'hFF80_0000};
        specs[1] = '{32'hC000_0000, 32'h7FC0_0000};
        specs[2] = '{32'h7F80_0000, 32'h7F80_0000};
        specs[3] = '{32'h7FC0_0001, 32'h7FC0_0000};
        specs[4] = '{32'h0000_0001, 32'hFF80_0000};

        #23;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_done",  {31'b0, done},  32'd0);
        chk("rst_s",     S,              32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h3F80_0000, 5'd24, s, lat);
        chk("one_val", s, 32'h0000_0000);
        chk("one_lat", lat, 27);
        @(posedge clk);
        #1 chk("done_pulse", {31'b0, done}, 32'd0);

        run_op(32'h4000_0000, 5'd24, s, lat);
        chk("ln2", s, 32'h3F31_7218, 2);
        run_op(32'h3F00_0000, 5'd24, s, lat);
        chk("ln_half", s, 32'hBF31_7218, 2);
        run_op(32'h402D_F854, 5'd24, s, lat);
        chk("ln_e", s, 32'h3F80_0000, 4);
        run_op(32'h7F7F_FFFF, 5'd24, s, lat);
        chk("ln_max", s, 32'h42B1_7218, 4);
        run_op(32'h4120_0000, 5'd24, s, lat);
        chk("ln_10", s, 32'h4013_5D8E, 4);

        foreach (specs[i]) begin
            run_op(specs[i].a, 5'd24, s, lat);
            chk($sformatf("spec%0d_val", i), s, specs[i].s);
            chk($sformatf("spec%0d_lat", i), lat, 2);
        end

        run_op(32'h4000_0000, 5'd0, s, lat);
        chk("n0_lat", lat, 4);
        run_op(32'h4000_0000, 5'd31, s, lat);
        chk("n31_lat", lat, 27);
        chk("n31_val", s, 32'h3F31_7218, 2);

        // start held high across a whole op, re-used in the done cycle
        @(negedge clk);
        A           = 32'h4000_0000;
        number_iter = 5'd24;
        start       = 1'b1;
        @(posedge clk);
        #1 cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
            if (cyc == 5) chk("busy_ready", {31'b0, ready}, 32'd0);
            if (done) break;
        end
        chk("hold_lat", cyc, 27);
        chk("hold_val", S, 32'h3F31_7218, 2);
        A = 32'h3F00_0000;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
            if (done) break;
        end
        chk("back2back_lat", cyc, 27);
        chk("back2back_val", S, 32'hBF31_7218, 2);
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) ndone++;
        end
        chk("no_extra_done", ndone, 0);

        // asynchronous reset landing between edges mid-iteration
        @(negedge clk);
        A     = 32'h402D_F854;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'b0, ready}, 32'd1);
        chk("arst_done",  {31'b0, done},  32'd0);
        chk("arst_s",     S,              32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (30) begin
            @(posedge clk);
            #1 if (done) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        run_op(32'h4120_0000, 5'd24, s, lat);
        chk("arst_next_val", s, 32'h4013_5D8E, 4);
        chk("arst_next_lat", lat, 27);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
